// File: rtl/axi_pmu_sampler.sv
// AXI4-Lite master that snapshots N_COUNTERS PMU counters and streams them to a valid/ready consumer.
// Define PMU_SAMPLER_AUTOCLEAR_EN to write CLEAR_VALUE to CONF_ADDR after the last sample.
module axi_pmu_sampler #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int N_COUNTERS         = 16,
  parameter int COUNTER_BASE       = 0,
  parameter int CONF_ADDR          = 64,
  parameter int CLEAR_VALUE        = 2,
  localparam int IDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
  input  logic                              M_AXI_ACLK_i,
  input  logic                              M_AXI_ARESET_i,
  input  logic                              start_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic                              sample_valid_o,
  input  logic                              sample_ready_i,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     sample_data_o,
  output logic [IDX_W-1:0]                  sample_idx_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR_o,
  output logic                              M_AXI_ARVALID_o,
  input  logic                              M_AXI_ARREADY_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA_i,
  input  logic [1:0]                        M_AXI_RRESP_i,
  input  logic                              M_AXI_RVALID_i,
  output logic                              M_AXI_RREADY_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR_o,
  output logic                              M_AXI_AWVALID_o,
  input  logic                              M_AXI_AWREADY_i,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA_o,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB_o,
  output logic                              M_AXI_WVALID_o,
  input  logic                              M_AXI_WREADY_i,
  input  logic [1:0]                        M_AXI_BRESP_i,
  input  logic                              M_AXI_BVALID_i,
  output logic                              M_AXI_BREADY_o
);

  typedef enum logic [2:0] {IDLE, AR, R, OUT, AW_W, B, DONE} state_e;

  state_e                          state_q;
  logic [IDX_W-1:0]                index_q;
  logic [IDX_W-1:0]                nextIndex_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   nextAddr_d;
  logic                            lastIndex_d;
  logic                            busy_q;
  logic                            done_q;
  logic                            err_q;
  logic                            sampleValid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   sampleData_q;
  logic [IDX_W-1:0]                sampleIdx_q;
  logic                            arValid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   arAddr_q;
  logic                            rReady_q;

`ifdef PMU_SAMPLER_AUTOCLEAR_EN
  logic                            awValid_q;
  logic                            wValid_q;
  logic                            bReady_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awAddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wData_q;
`endif

  always_comb begin
    nextIndex_d = index_q + 1'b1;
    nextAddr_d  = C_M_AXI_ADDR_WIDTH'(COUNTER_BASE) + (C_M_AXI_ADDR_WIDTH'(nextIndex_d) << 2);
    lastIndex_d = (index_q == IDX_W'(N_COUNTERS - 1));
  end

  // Single outstanding read: each counter walks AR -> R -> OUT before the next address is issued.
  always_ff @(posedge M_AXI_ACLK_i or posedge M_AXI_ARESET_i) begin
    if (M_AXI_ARESET_i) begin
      state_q       <= IDLE;
      index_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      sampleValid_q <= 1'b0;
      sampleData_q  <= '0;
      sampleIdx_q   <= '0;
      arValid_q     <= 1'b0;
      arAddr_q      <= '0;
      rReady_q      <= 1'b0;
`ifdef PMU_SAMPLER_AUTOCLEAR_EN
      awValid_q     <= 1'b0;
      wValid_q      <= 1'b0;
      bReady_q      <= 1'b0;
      awAddr_q      <= '0;
      wData_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            index_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            arValid_q <= 1'b1;
            arAddr_q  <= C_M_AXI_ADDR_WIDTH'(COUNTER_BASE);
            state_q   <= AR;
          end
        end
        AR: begin
          if (M_AXI_ARREADY_i) begin
            arValid_q <= 1'b0;
            rReady_q  <= 1'b1;
            state_q   <= R;
          end
        end
        R: begin
          if (M_AXI_RVALID_i) begin
            rReady_q      <= 1'b0;
            sampleData_q  <= M_AXI_RDATA_i;
            sampleIdx_q   <= index_q;
            sampleValid_q <= 1'b1;
            if (M_AXI_RRESP_i != 2'b00) begin
              err_q <= 1'b1;
            end
            state_q <= OUT;
          end
        end
        OUT: begin
          if (sample_ready_i) begin
            sampleValid_q <= 1'b0;
            if (lastIndex_d) begin
`ifdef PMU_SAMPLER_AUTOCLEAR_EN
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
              awAddr_q  <= C_M_AXI_ADDR_WIDTH'(CONF_ADDR);
              wData_q   <= C_M_AXI_DATA_WIDTH'(CLEAR_VALUE);
              state_q   <= AW_W;
`else
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              index_q   <= nextIndex_d;
              arValid_q <= 1'b1;
              arAddr_q  <= nextAddr_d;
              state_q   <= AR;
            end
          end
        end
`ifdef PMU_SAMPLER_AUTOCLEAR_EN
        // AW and W retire independently; leave once neither is still pending after this edge.
        AW_W: begin
          if (M_AXI_AWREADY_i) begin
            awValid_q <= 1'b0;
          end
          if (M_AXI_WREADY_i) begin
            wValid_q <= 1'b0;
          end
          if ((!awValid_q || M_AXI_AWREADY_i) && (!wValid_q || M_AXI_WREADY_i)) begin
            bReady_q <= 1'b1;
            state_q  <= B;
          end
        end
        B: begin
          if (M_AXI_BVALID_i) begin
            bReady_q <= 1'b0;
            if (M_AXI_BRESP_i != 2'b00) begin
              err_q <= 1'b1;
            end
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign sample_valid_o  = sampleValid_q;
  assign sample_data_o   = sampleData_q;
  assign sample_idx_o    = sampleIdx_q;
  assign M_AXI_ARADDR_o  = arAddr_q;
  assign M_AXI_ARVALID_o = arValid_q;
  assign M_AXI_RREADY_o  = rReady_q;

`ifdef PMU_SAMPLER_AUTOCLEAR_EN
  assign M_AXI_AWADDR_o  = awAddr_q;
  assign M_AXI_AWVALID_o = awValid_q;
  assign M_AXI_WDATA_o   = wData_q;
  assign M_AXI_WSTRB_o   = '1;
  assign M_AXI_WVALID_o  = wValid_q;
  assign M_AXI_BREADY_o  = bReady_q;
`else
  logic unusedWriteInputs;
  assign unusedWriteInputs = ^{M_AXI_AWREADY_i, M_AXI_WREADY_i, M_AXI_BRESP_i, M_AXI_BVALID_i};
  assign M_AXI_AWADDR_o  = '0;
  assign M_AXI_AWVALID_o = 1'b0;
  assign M_AXI_WDATA_o   = '0;
  assign M_AXI_WSTRB_o   = '0;
  assign M_AXI_WVALID_o  = 1'b0;
  assign M_AXI_BREADY_o  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_pmu_sampler.sv
// Scoreboard bench for axi_pmu_sampler: AXI slave model, stalling consumer, queue-based sample/address checking.
// Write-phase expectations follow PMU_SAMPLER_AUTOCLEAR_EN.
module tb_axi_pmu_sampler;

  localparam int DW   = 32;
  localparam int AW   = 7;
  localparam int N    = 16;
  localparam int IW   = 4;
  localparam int CONF = 64;
  localparam int CLR  = 2;
`ifdef PMU_SAMPLER_AUTOCLEAR_EN
  localparam int EXTRA_WR = 4;
`else
  localparam int EXTRA_WR = 0;
`endif
  localparam int EXP_DONE_FAST  = 49 + EXTRA_WR;
  localparam int EXP_DONE_STALL = 49 + 3 * N + 5 + EXTRA_WR;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } sample_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy_o, done_o, err_o;
  logic            sample_valid_o, sample_ready;
  logic [DW-1:0]   sample_data_o;
  logic [IW-1:0]   sample_idx_o;
  logic [AW-1:0]   araddr_o;
  logic            arvalid_o, arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid, rready_o;
  logic [AW-1:0]   awaddr_o;
  logic            awvalid_o, awready;
  logic [DW-1:0]   wdata_o;
  logic [DW/8-1:0] wstrb_o;
  logic            wvalid_o, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready_o;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int writeCount = 0;
  logic [AW-1:0]   lastWAddr;
  logic [DW-1:0]   lastWData;
  logic [DW/8-1:0] lastWStrb;

  int arDelay = 0;
  int rDelay = 0;
  int awDelay = 2;
  int wDelay = 0;
  int errIdx = -1;
  int stallIdx = -1;
  int stallLeft = 0;

  sample_t       sampQ[$];
  logic [AW-1:0] addrQ[$];

  axi_pmu_sampler #(
    .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .N_COUNTERS(N),
    .COUNTER_BASE(0), .CONF_ADDR(CONF), .CLEAR_VALUE(CLR)
  ) dut (
    .M_AXI_ACLK_i(clk), .M_AXI_ARESET_i(rst), .start_i(start),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready),
    .sample_data_o(sample_data_o), .sample_idx_o(sample_idx_o),
    .M_AXI_ARADDR_o(araddr_o), .M_AXI_ARVALID_o(arvalid_o), .M_AXI_ARREADY_i(arready),
    .M_AXI_RDATA_i(rdata), .M_AXI_RRESP_i(rresp), .M_AXI_RVALID_i(rvalid), .M_AXI_RREADY_o(rready_o),
    .M_AXI_AWADDR_o(awaddr_o), .M_AXI_AWVALID_o(awvalid_o), .M_AXI_AWREADY_i(awready),
    .M_AXI_WDATA_o(wdata_o), .M_AXI_WSTRB_o(wstrb_o), .M_AXI_WVALID_o(wvalid_o), .M_AXI_WREADY_i(wready),
    .M_AXI_BRESP_i(bresp), .M_AXI_BVALID_i(bvalid), .M_AXI_BREADY_o(bready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %s", name, what);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctrl"},
                {busy_o, done_o, err_o, sample_valid_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o,
                 sample_idx_o, araddr_o, awaddr_o}, 64'd0);
    checkOutput({name, "_data"}, {sample_data_o, wdata_o}, 64'd0);
  endtask

  // Slave model: drives on the falling edge; a ready/valid it raised last time was consumed at the rising edge between.
  initial begin : slave
    int arWait, rWait, awWait, wWait, i;
    bit rPend, awSeen, wSeen;
    logic [AW-1:0] rdAddr, wrAddr;
    logic [DW-1:0] wrData;
    logic [DW/8-1:0] wrStrb;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arWait = 0; rWait = 0; awWait = 0; wWait = 0; rPend = 0; awSeen = 0; wSeen = 0;
    rdAddr = '0; wrAddr = '0; wrData = '0; wrStrb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0;
        arWait = 0; rWait = 0; awWait = 0; wWait = 0; rPend = 0; awSeen = 0; wSeen = 0;
      end else begin
        if (rvalid) begin rvalid = 0; rresp = 0; rPend = 0; end
        if (arready) begin arready = 0; rPend = 1; arWait = 0; rWait = 0; end
        if (awready) begin awready = 0; awSeen = 1; awWait = 0; end
        if (wready) begin wready = 0; wSeen = 1; wWait = 0; end
        if (bvalid) begin bvalid = 0; awSeen = 0; wSeen = 0; end
        if (arvalid_o && !rPend) begin
          if (arWait >= arDelay) begin arready = 1; rdAddr = araddr_o; end
          else arWait++;
        end
        if (rPend && !rvalid) begin
          if (rWait >= rDelay) begin
            i = int'(rdAddr) >> 2;
            rvalid = 1;
            rdata = DW'(100 + i);
            rresp = (i == errIdx) ? 2'b10 : 2'b00;
          end else rWait++;
        end
        if (awvalid_o && !awSeen) begin
          if (awWait >= awDelay) begin awready = 1; wrAddr = awaddr_o; end
          else awWait++;
        end
        if (wvalid_o && !wSeen) begin
          if (wWait >= wDelay) begin wready = 1; wrData = wdata_o; wrStrb = wstrb_o; end
          else wWait++;
        end
        if (awSeen && wSeen && !bvalid) begin
          bvalid = 1; bresp = 2'b00;
          writeCount++; lastWAddr = wrAddr; lastWData = wrData; lastWStrb = wrStrb;
        end
      end
    end
  end

  initial begin : consumer
    sample_ready = 1;
    forever begin
      @(negedge clk);
      if (!rst && sample_valid_o && int'(sample_idx_o) == stallIdx && stallLeft > 0) begin
        sample_ready = 0;
        stallLeft--;
      end else begin
        sample_ready = 1;
      end
    end
  end

  // Monitor samples mid-cycle, after the falling-edge drivers and before the next rising edge.
  initial begin : monitor
    bit arPrev, arHsPrev, svPrev, svHsPrev, donePrev;
    arPrev = 0; arHsPrev = 0; svPrev = 0; svHsPrev = 0; donePrev = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        arPrev = 0; arHsPrev = 0; svPrev = 0; svHsPrev = 0; donePrev = 0;
      end else begin
        if (arvalid_o) begin
          if (addrQ.size() == 0) failNow("ar_unexpected", $sformatf("ARADDR 0x%0h, expected no read", araddr_o));
          else begin
            checkOutput("araddr", araddr_o, addrQ[0]);
            if (arready) void'(addrQ.pop_front());
          end
        end else if (arPrev && !arHsPrev) failNow("arvalid_dropped", "ARVALID 0 before ARREADY, expected 1");
        arPrev = arvalid_o;
        arHsPrev = arvalid_o && arready;

        if (sample_valid_o) begin
          if (sampQ.size() == 0) failNow("sample_unexpected", $sformatf("idx %0d, expected none", sample_idx_o));
          else begin
            checkOutput("sample", {sample_idx_o, sample_data_o}, sampQ[0]);
            if (sample_ready) void'(sampQ.pop_front());
          end
        end else if (svPrev && !svHsPrev) failNow("sample_valid_dropped", "valid 0 before ready, expected 1");
        svPrev = sample_valid_o;
        svHsPrev = sample_valid_o && sample_ready;

        if (done_o) begin
          doneCount++;
          if (donePrev) failNow("done_width", "done_o high 2 cycles, expected 1");
        end
        donePrev = done_o;

`ifdef PMU_SAMPLER_AUTOCLEAR_EN
        if (awvalid_o) checkOutput("awaddr", awaddr_o, 64'(CONF));
        if (wvalid_o) checkOutput("wdata_wstrb", {wdata_o, wstrb_o}, {32'(CLR), 4'hF});
`else
        checkOutput("write_idle", {awvalid_o, wvalid_o, bready_o, awaddr_o, wdata_o, wstrb_o}, 64'd0);
`endif
      end
    end
  end

  task automatic applyStimulus(input int arD, input int stIdx, input int eIdx, input bit extra,
                               input bit expErr, input int expDone);
    int doneCyc, startDone, wrBefore;
    arDelay = arD; rDelay = 0; stallIdx = stIdx; stallLeft = (stIdx >= 0) ? 5 : 0; errIdx = eIdx;
    for (int i = 0; i < N; i++) begin
      sampQ.push_back('{idx: IW'(i), data: DW'(100 + i)});
      addrQ.push_back(AW'(4 * i));
    end
    startDone = doneCount;
    wrBefore = writeCount;
    @(negedge clk);
    start = 1;
    #3;
    checkOutput("busy_before_start", busy_o, 0);
    doneCyc = -1;
    for (int cyc = 1; cyc <= 400 && doneCyc < 0; cyc++) begin
      @(negedge clk);
      start = extra && (cyc == 6 || cyc == 30);
      #3;
      if (cyc == 1) begin
        checkOutput("busy_after_start", busy_o, 1);
        checkOutput("err_cleared_on_start", err_o, 0);
      end
      if (done_o) begin
        doneCyc = cyc;
        if (extra) start = 1;
      end
    end
    if (doneCyc < 0) failNow("done_timeout", "no done_o in 400 cycles, expected a pulse");
    else checkOutput("done_cycle", doneCyc, expDone);
    @(negedge clk);
    start = 0;
    #3;
    checkOutput("busy_after_done", busy_o, 0);
    checkOutput("err_o", err_o, expErr);
    repeat (4) @(negedge clk);
    #3;
    checkOutput("idle_no_restart", {busy_o, arvalid_o}, 0);
    checkOutput("done_pulses", doneCount - startDone, 1);
    checkOutput("samples_drained", sampQ.size(), 0);
    checkOutput("reads_drained", addrQ.size(), 0);
`ifdef PMU_SAMPLER_AUTOCLEAR_EN
    checkOutput("clear_writes", writeCount - wrBefore, 1);
    checkOutput("clear_write", {lastWAddr, lastWData, lastWStrb}, {7'(CONF), 32'(CLR), 4'hF});
`else
    checkOutput("no_writes", writeCount - wrBefore, 0);
`endif
  endtask

  initial begin : stimulus
    bit found;
    rst = 1;
    start = 0;
    repeat (2) @(negedge clk);
    #3;
    checkAllZero("reset_state");
    @(negedge clk);
    rst = 0;

    $display("[TB] zero-wait snapshot");
    applyStimulus(0, -1, -1, 0, 0, EXP_DONE_FAST);
    $display("[TB] ARREADY delay 3, consumer stall on idx 7");
    applyStimulus(3, 7, -1, 0, 0, EXP_DONE_STALL);
    $display("[TB] RRESP error on counter 4");
    applyStimulus(0, -1, 4, 0, 1, EXP_DONE_FAST);
    $display("[TB] start pulses while busy and in DONE");
    applyStimulus(0, -1, -1, 1, 0, EXP_DONE_FAST);

    $display("[TB] reset during read");
    arDelay = 0; rDelay = 4; stallIdx = -1; stallLeft = 0; errIdx = -1;
    for (int i = 0; i < N; i++) begin
      sampQ.push_back('{idx: IW'(i), data: DW'(100 + i)});
      addrQ.push_back(AW'(4 * i));
    end
    @(negedge clk);
    start = 1;
    found = 0;
    for (int cyc = 1; cyc <= 200 && !found; cyc++) begin
      @(negedge clk);
      start = 0;
      #3;
      if (rready_o && cyc >= 10) found = 1;
    end
    if (!found) failNow("reach_read_state", "RREADY never high, expected R state");
    rst = 1;
    #1;
    checkAllZero("reset_in_read");
    sampQ.delete();
    addrQ.delete();
    rDelay = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    $display("[TB] fresh snapshot after reset");
    applyStimulus(0, -1, -1, 0, 0, EXP_DONE_FAST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_pmu_sampler.md
Name: axi_pmu_sampler

Overview:
- AXI4-Lite master that drives the slave port of the PMU block, the initiator end of the same interface.
- On a start pulse it reads N_COUNTERS counter registers in order and hands each value to a local consumer over a valid/ready sample port.
- Used by on-chip monitors and debug logic to snapshot PMU counters without CPU involvement.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; also the sample width.
- C_M_AXI_ADDR_WIDTH, 7, AXI address width; matches the PMU slave.
- N_COUNTERS, 16, number of counters read per snapshot; legal range 1..2^(C_M_AXI_ADDR_WIDTH-2).
- COUNTER_BASE, 0, byte address of counter 0; counter i is at COUNTER_BASE + 4*i.
- CONF_ADDR, 64, byte address of the PMU main configuration register.
- CLEAR_VALUE, 2, value written to CONF_ADDR by the optional clear phase.

Ports:
- M_AXI_ACLK_i  in  1  clock
- M_AXI_ARESET_i  in  1  asynchronous reset, active-high
- start_i  in  1  snapshot request pulse; ignored while busy_o=1
- busy_o  out  1  snapshot in progress
- done_o  out  1  one-cycle pulse when a snapshot completes
- err_o  out  1  sticky; set by any non-OKAY RRESP or BRESP; cleared by the next accepted start_i
- sample_valid_o  out  1  sample available
- sample_ready_i  in  1  consumer accepts the sample
- sample_data_o  out  C_M_AXI_DATA_WIDTH  counter value
- sample_idx_o  out  $clog2(N_COUNTERS) (min 1)  counter index
- M_AXI_ARADDR_o  out  C_M_AXI_ADDR_WIDTH  read address
- M_AXI_ARVALID_o  out  1  read address valid
- M_AXI_ARREADY_i  in  1  read address ready
- M_AXI_RDATA_i  in  C_M_AXI_DATA_WIDTH  read data
- M_AXI_RRESP_i  in  2  read response
- M_AXI_RVALID_i  in  1  read data valid
- M_AXI_RREADY_o  out  1  read data ready
- M_AXI_AWADDR_o  out  C_M_AXI_ADDR_WIDTH  write address
- M_AXI_AWVALID_o  out  1  write address valid
- M_AXI_AWREADY_i  in  1  write address ready
- M_AXI_WDATA_o  out  C_M_AXI_DATA_WIDTH  write data
- M_AXI_WSTRB_o  out  C_M_AXI_DATA_WIDTH/8  write strobes; all ones
- M_AXI_WVALID_o  out  1  write data valid
- M_AXI_WREADY_i  in  1  write data ready
- M_AXI_BRESP_i  in  2  write response
- M_AXI_BVALID_i  in  1  write response valid
- M_AXI_BREADY_o  out  1  write response ready

Behaviour:
- Reset: all valid/ready outputs, busy_o, done_o, err_o, sample_data_o, sample_idx_o and the address/data outputs are 0. State is IDLE. Reset mid-transaction drops everything immediately; no AXI completion is attempted.
- FSM states: IDLE, AR, R, OUT, AW_W, B, DONE.
- IDLE: start_i=1 -> index=0, err_o cleared, busy_o=1 next cycle, go to AR.
- AR: ARVALID=1 with ARADDR=COUNTER_BASE+4*index, both stable until ARREADY. ARVALID&ARREADY -> R.
- R: RREADY=1. On RVALID, capture RDATA into sample_data_o and index into sample_idx_o; any RRESP!=0 sets err_o (data is still forwarded). Go to OUT.
- OUT: sample_valid_o=1, data stable until sample_ready_i. On handshake: if index==N_COUNTERS-1 go to the clear phase (AW_W, if enabled) else DONE; otherwise index+1 and go to AR.
- Only one read is outstanding at a time. Minimum latency per counter is 3 cycles (AR, R, OUT with zero-wait slave and consumer).
- DONE: done_o=1 for one cycle, busy_o=0 next cycle, return to IDLE. A start_i asserted in DONE is ignored.
- Write channel outputs stay 0 unless the clear phase is enabled.

Optional Feature:
- Macro: PMU_SAMPLER_AUTOCLEAR_EN.
- Defined: after the last sample, enter AW_W. AWVALID (AWADDR=CONF_ADDR) and WVALID (WDATA=CLEAR_VALUE, WSTRB all ones) are asserted together and each is dropped independently on its own handshake; either order, or both in the same cycle, is legal. Once both are accepted, go to B. B: BREADY=1 until BVALID; BRESP!=0 sets err_o; then DONE.
- Undefined: AW_W and B are never entered; all write outputs are tied to 0.

Test Plan:
- Zero-wait slave returning 100+i for counter i, sample_ready_i held high, N_COUNTERS=16 -> 16 samples, idx 0..15, data 100..115, ARADDR 0x00..0x3C, done_o pulses once, total 48+2 cycles.
- ARREADY delayed 3 cycles and sample_ready_i low for 5 cycles on idx 7 -> ARADDR and ARVALID stable throughout; sample 7 held unchanged until accepted; no extra AR issued.
- RRESP=2 on counter 4 -> err_o set, data still delivered, all 16 reads complete; next start_i clears err_o.
- start_i pulsed while busy_o=1 and during DONE -> ignored; exactly one snapshot and one done_o.
- Reset asserted while in R with RVALID pending -> all outputs 0 in the same cycle; a fresh start_i reads from idx 0.
- AUTOCLEAR_EN with WREADY arriving 2 cycles before AWREADY, then BRESP=0 -> single write of 0x2 to 0x40, err_o=0, done_o after BVALID.
